// File: rtl/multi_edge_detect.sv
// multi_edge_detect: N-channel synchronised, debounced edge detector.
//
// Each channel passes its raw input through a SYNC_STAGES-deep synchroniser
// and a debounce filter. It then produces a one-cycle tick on the edges that
// its mode selects. A tick sets a sticky pending flag, which clr clears.
// irq is the OR of all pending flags.
//
// Optional feature (macro EDGE_COUNT_EN): each channel also has a saturating
// CNT_W-bit event counter, exposed on evt_cnt.
//
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous active-high reset
//   in      - raw, possibly asynchronous inputs (N)
//   mode    - per channel [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   clr     - per-channel pending clear, one-cycle pulse (N)
//   tick    - one-cycle edge strobe per channel (N)
//   pend    - sticky pending flag per channel (N)
//   irq     - OR of all pend bits
//   evt_cnt - per-channel event count, N*CNT_W (EDGE_COUNT_EN only)
module multi_edge_detect #(
  parameter int unsigned N           = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 4,
  parameter int unsigned DB_W        = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in,
  input  logic [2*N-1:0]   mode,
  input  logic [N-1:0]     clr,
  output logic [N-1:0]     tick,
  output logic [N-1:0]     pend,
  output logic             irq
`ifdef EDGE_COUNT_EN
  ,
  output logic [N*CNT_W-1:0] evt_cnt
`endif
);

  // DEBOUNCE of 0 or 1 both mean that the filter follows sync on the next edge.
  localparam int unsigned D = (DEBOUNCE < 1) ? 1 : DEBOUNCE;
  localparam logic [DB_W-1:0] DbLast = DB_W'(D - 1);

  if (N < 1 || N > 32 || SYNC_STAGES < 2 || CNT_W < 1 ||
      DEBOUNCE >= (32'd1 << DB_W)) begin : g_param_check
    $error("multi_edge_detect: illegal parameter combination");
  end

  // Synchroniser: stage 0 samples the raw input. The last stage is the
  // synchronised level.
  logic [SYNC_STAGES-1:0][N-1:0] sync_q;
  logic [N-1:0]                  sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Debounce filter and delayed copy for edge detection.
  logic [N-1:0]           filt_q, filt_d, filt_dly_q;
  logic [N-1:0][DB_W-1:0] db_cnt_q, db_cnt_d;

  always_comb begin
    filt_d   = filt_q;
    db_cnt_d = '0;
    for (int i = 0; i < N; i++) begin
      if (sync[i] != filt_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          filt_d[i] = sync[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q     <= '0;
      filt_dly_q <= '0;
      db_cnt_q   <= '0;
    end else begin
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      db_cnt_q   <= db_cnt_d;
    end
  end

  // Edge detection. mode is applied live. A mode change cannot create an edge
  // because the edge terms come only from the filtered flops.
  logic [N-1:0] rise, fall, mode_rise, mode_fall;

  always_comb begin
    mode_rise = '0;
    mode_fall = '0;
    for (int i = 0; i < N; i++) begin
      mode_rise[i] = mode[2*i];
      mode_fall[i] = mode[2*i+1];
    end
  end

  assign rise = filt_q & ~filt_dly_q;
  assign fall = ~filt_q & filt_dly_q;
  assign tick = (rise & mode_rise) | (fall & mode_fall);

  // Pending flags: a tick has priority over a clear in the same cycle.
  logic [N-1:0] pend_q, pend_d;

  assign pend_d = (pend_q & ~clr) | tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;
  assign irq  = |pend_q;

`ifdef EDGE_COUNT_EN
  // Saturating event counters. A clear together with a tick leaves a count of 1.
  logic [N-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < N; i++) begin
      if (clr[i]) begin
        cnt_d[i] = tick[i] ? CNT_W'(1) : '0;
      end else if (tick[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign evt_cnt = cnt_q;
`endif

endmodule
